// File: rtl/cells_commit_if.sv
// cells_commit_if
// Bundles the copy-back engine's control and memory-port signals.
//   start_i, vram_grant_i, ram_rd_data_i : into the engine
//   ram_rd_address_o                      : next-state RAM read port
//   ram_wr_address_o/data_o/en_o          : next-state RAM clear port
//   vram_wr_address_o/data_o/en_o         : VRAM write port
//   busy_o, done_o                        : pass status
// master = the commit engine, slave = the surrounding memories/controller.
interface cells_commit_if #(
    parameter int ADDR_WIDTH = 19,
    parameter int DATA_WIDTH = 2
);
    logic                  start_i;
    logic                  vram_grant_i;
    logic [DATA_WIDTH-1:0] ram_rd_data_i;
    logic [ADDR_WIDTH-1:0] ram_rd_address_o;
    logic [ADDR_WIDTH-1:0] ram_wr_address_o;
    logic [DATA_WIDTH-1:0] ram_wr_data_o;
    logic                  ram_wr_en_o;
    logic [ADDR_WIDTH-1:0] vram_wr_address_o;
    logic [DATA_WIDTH-1:0] vram_wr_data_o;
    logic                  vram_wr_en_o;
    logic                  busy_o;
    logic                  done_o;

    modport master (
        input  start_i, vram_grant_i, ram_rd_data_i,
        output ram_rd_address_o, ram_wr_address_o, ram_wr_data_o, ram_wr_en_o,
        output vram_wr_address_o, vram_wr_data_o, vram_wr_en_o, busy_o, done_o
    );

    modport slave (
        output start_i, vram_grant_i, ram_rd_data_i,
        input  ram_rd_address_o, ram_wr_address_o, ram_wr_data_o, ram_wr_en_o,
        input  vram_wr_address_o, vram_wr_data_o, vram_wr_en_o, busy_o, done_o
    );
endinterface

// File: rtl/cells_commit.sv
// cells_commit
// Copies every cell of the next-state RAM into VRAM in raster order and,
// when CLEAR_RAM=1, zeroes each RAM cell as it is committed.
// Ports:
//   clk_i   : single clock, rising edge
//   reset_i : asynchronous, active-low reset
//   bus     : cells_commit_if.master (start, VRAM grant, RAM read/clear,
//             VRAM write, busy/done status)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start_i
// COPY  | issuing reads 0..N-1, committing the previous read on grant
// DRAIN | last read issued, waiting to commit cell N-1
// DONE  | one-cycle done_o pulse, busy_o still high
module cells_commit #(
    parameter int ACTIVE_COLUMNS = 640,
    parameter int ACTIVE_ROWS    = 480,
    parameter int ADDR_WIDTH     = $clog2(ACTIVE_COLUMNS * ACTIVE_ROWS),
    parameter int DATA_WIDTH     = 2,
    parameter bit CLEAR_RAM      = 1'b1
) (
    input  logic           clk_i,
    input  logic           reset_i,
    cells_commit_if.master bus
);
    localparam int                    N_CELLS   = ACTIVE_COLUMNS * ACTIVE_ROWS;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N_CELLS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COPY,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] rd_ptr, rd_ptr_nxt;
    logic [ADDR_WIDTH-1:0] wr_ptr, wr_ptr_nxt;
    logic                  valid, valid_nxt;
    logic                  in_pass;
    logic                  commit;
    logic                  stall;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state  <= S_IDLE;
            rd_ptr <= '0;
            wr_ptr <= '0;
            valid  <= 1'b0;
        end else begin
            state  <= state_nxt;
            rd_ptr <= rd_ptr_nxt;
            wr_ptr <= wr_ptr_nxt;
            valid  <= valid_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        rd_ptr_nxt = rd_ptr;
        wr_ptr_nxt = wr_ptr;
        valid_nxt  = valid;

        bus.ram_rd_address_o  = '0;
        bus.ram_wr_address_o  = '0;
        bus.ram_wr_data_o     = '0;
        bus.ram_wr_en_o       = 1'b0;
        bus.vram_wr_address_o = '0;
        bus.vram_wr_data_o    = '0;
        bus.vram_wr_en_o      = 1'b0;
        bus.busy_o            = (state != S_IDLE);
        bus.done_o            = 1'b0;

        in_pass = (state == S_COPY) || (state == S_DRAIN);
        commit  = in_pass && valid && bus.vram_grant_i;
        stall   = in_pass && valid && !bus.vram_grant_i;

        // The cell on ram_rd_data_i belongs to wr_ptr; the concurrent read
        // targets wr_ptr+1, so clearing wr_ptr never races the read.
        if (commit) begin
            bus.vram_wr_en_o      = 1'b1;
            bus.vram_wr_address_o = wr_ptr;
            bus.vram_wr_data_o    = bus.ram_rd_data_i;
            if (CLEAR_RAM) begin
                bus.ram_wr_en_o      = 1'b1;
                bus.ram_wr_address_o = wr_ptr;
            end
        end

        // On a stall the pending cell is read again so its data is still
        // on ram_rd_data_i when the grant comes back.
        if (stall) begin
            bus.ram_rd_address_o = wr_ptr;
        end

        case (state)
            S_IDLE: begin
                if (bus.start_i) begin
                    rd_ptr_nxt = '0;
                    valid_nxt  = 1'b0;
                    state_nxt  = S_COPY;
                end
            end
            S_COPY: begin
                if (!stall) begin
                    bus.ram_rd_address_o = rd_ptr;
                    wr_ptr_nxt           = rd_ptr;
                    valid_nxt            = 1'b1;
                    if (rd_ptr == LAST_ADDR) begin
                        state_nxt = S_DRAIN;
                    end else begin
                        rd_ptr_nxt = rd_ptr + ADDR_WIDTH'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (commit) begin
                    valid_nxt = 1'b0;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                bus.done_o = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_cells_commit.sv
module tb_cells_commit;
    localparam int COLS  = 4;
    localparam int ROWS  = 3;
    localparam int N     = COLS * ROWS;
    localparam int AW    = 4;
    localparam int DW    = 2;
    localparam int DEPTH = 16;
    localparam int PLEN  = 80;
    localparam int NVEC  = 7;

    typedef struct packed {
        logic [AW-1:0] rd_addr;
        logic [AW-1:0] ram_wa;
        logic [DW-1:0] ram_wd;
        logic          ram_we;
        logic [AW-1:0] vram_wa;
        logic [DW-1:0] vram_wd;
        logic          vram_we;
        logic          busy;
        logic          done;
    } obs_t;

    // One directed pass: grant dropped for stall_len cycles from stall_from
    // (offsets relative to the start cycle), optional start hold / poke,
    // and the expected commit time of one probe address plus done time.
    typedef struct {
        string name;
        int    stall_from;
        int    stall_len;
        bit    hold_start;
        int    poke_at;
        int    probe_addr;
        int    exp_probe_off;
        int    exp_done;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic grant = 1'b1;
    logic load_en = 1'b0;

    logic [DW-1:0] init_img [DEPTH];
    logic [DW-1:0] ram_a    [DEPTH];
    logic [DW-1:0] ram_b    [DEPTH];
    logic [DW-1:0] vram_a   [DEPTH];
    logic [DW-1:0] vram_b   [DEPTH];

    int   n_cmp = 0;
    int   n_bad = 0;
    int   obs_done;
    int   obs_commit_off [N];
    vec_t vecs [NVEC];
    obs_t obs_a, obs_b;

    cells_commit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_a ();
    cells_commit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_b ();

    assign bus_a.start_i      = start;
    assign bus_b.start_i      = start;
    assign bus_a.vram_grant_i = grant;
    assign bus_b.vram_grant_i = grant;

    cells_commit #(.ACTIVE_COLUMNS(COLS), .ACTIVE_ROWS(ROWS), .ADDR_WIDTH(AW),
                   .DATA_WIDTH(DW), .CLEAR_RAM(1'b1))
        u_dut_a (.clk_i(clk), .reset_i(rst_n), .bus(bus_a.master));

    cells_commit #(.ACTIVE_COLUMNS(COLS), .ACTIVE_ROWS(ROWS), .ADDR_WIDTH(AW),
                   .DATA_WIDTH(DW), .CLEAR_RAM(1'b0))
        u_dut_b (.clk_i(clk), .reset_i(rst_n), .bus(bus_b.master));

    assign obs_a = {bus_a.ram_rd_address_o, bus_a.ram_wr_address_o, bus_a.ram_wr_data_o,
                    bus_a.ram_wr_en_o, bus_a.vram_wr_address_o, bus_a.vram_wr_data_o,
                    bus_a.vram_wr_en_o, bus_a.busy_o, bus_a.done_o};
    assign obs_b = {bus_b.ram_rd_address_o, bus_b.ram_wr_address_o, bus_b.ram_wr_data_o,
                    bus_b.ram_wr_en_o, bus_b.vram_wr_address_o, bus_b.vram_wr_data_o,
                    bus_b.vram_wr_en_o, bus_b.busy_o, bus_b.done_o};

    always #5 clk = ~clk;

    // Next-state RAMs (1-cycle read latency) and VRAMs for both engines.
    always @(posedge clk) begin
        bus_a.ram_rd_data_i <= ram_a[bus_a.ram_rd_address_o];
        bus_b.ram_rd_data_i <= ram_b[bus_b.ram_rd_address_o];
        if (load_en) begin
            ram_a <= init_img;
            ram_b <= init_img;
            for (int i = 0; i < DEPTH; i++) begin
                vram_a[i] <= 2'd3;
                vram_b[i] <= 2'd3;
            end
        end else begin
            if (bus_a.ram_wr_en_o)  ram_a[bus_a.ram_wr_address_o]   <= bus_a.ram_wr_data_o;
            if (bus_b.ram_wr_en_o)  ram_b[bus_b.ram_wr_address_o]   <= bus_b.ram_wr_data_o;
            if (bus_a.vram_wr_en_o) vram_a[bus_a.vram_wr_address_o] <= bus_a.vram_wr_data_o;
            if (bus_b.vram_wr_en_o) vram_b[bus_b.vram_wr_address_o] <= bus_b.vram_wr_data_o;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // k < 0 means no commit expected this cycle.
    task automatic chk_obs(input string tag, input obs_t o, input bit clr, input int k,
                           input int d, input int er, input bit be, input bit de);
        bit we  = (k >= 0);
        bit rwe = clr && we;
        chk({tag, " vram_wr_en"},   int'(o.vram_we), int'(we));
        chk({tag, " vram_wr_addr"}, int'(o.vram_wa), we ? k : 0);
        chk({tag, " vram_wr_data"}, int'(o.vram_wd), we ? d : 0);
        chk({tag, " ram_wr_en"},    int'(o.ram_we),  int'(rwe));
        chk({tag, " ram_wr_addr"},  int'(o.ram_wa),  rwe ? k : 0);
        chk({tag, " ram_wr_data"},  int'(o.ram_wd),  0);
        chk({tag, " ram_rd_addr"},  int'(o.rd_addr), er);
        chk({tag, " busy"},         int'(o.busy),    int'(be));
        chk({tag, " done"},         int'(o.done),    int'(de));
    endtask

    task automatic chk_idle(input string tag);
        chk_obs({tag, "/a"}, obs_a, 1'b1, -1, 0, 0, 1'b0, 1'b0);
        chk_obs({tag, "/b"}, obs_b, 1'b0, -1, 0, 0, 1'b0, 1'b0);
    endtask

    // Called and returns 1 time unit after a rising edge.
    task automatic preload(input bit rnd);
        for (int k = 0; k < DEPTH; k++) begin
            if (k >= N)   init_img[k] = '0;
            else if (rnd) init_img[k] = DW'($urandom_range(0, 3));
            else          init_img[k] = DW'(k % 4);
        end
        load_en = 1'b1;
        @(posedge clk); #1;
        load_en = 1'b0;
    endtask

    // Reference: from T+2 on one cell is always pending; it is committed in
    // each granted cycle, in address order. done follows the last commit.
    task automatic run_pass(input string tag, input bit rnd, input int sf, input int sl,
                            input bit hold, input int poke);
        bit gp [PLEN];
        int commit_at [PLEN];
        int done_off, c, t, k, d, er;
        for (int i = 0; i < PLEN; i++) begin
            if (rnd) gp[i] = (i >= 40) || ($urandom_range(0, 3) != 0);
            else     gp[i] = !(i >= sf && i < sf + sl);
            commit_at[i] = -1;
        end
        c = 0;
        t = 2;
        while (c < N) begin
            if (gp[t]) begin
                commit_at[t] = c;
                c++;
            end
            t++;
        end
        done_off = t;
        for (int i = 0; i < N; i++) obs_commit_off[i] = -1;
        obs_done = -1;
        c = 0;
        for (int o = 0; o <= done_off + 3; o++) begin
            start = (o == 0) || (hold && o <= done_off) || (o == poke);
            grant = gp[o];
            @(negedge clk);
            k = commit_at[o];
            d = (k >= 0) ? int'(init_img[k]) : 0;
            if (o >= 2 && o < done_off) er = gp[o] ? ((c + 1 < N) ? c + 1 : 0) : c;
            else                        er = 0;
            chk_obs({tag, "/a"}, obs_a, 1'b1, k, d, er, (o >= 1 && o <= done_off), (o == done_off));
            chk_obs({tag, "/b"}, obs_b, 1'b0, k, d, er, (o >= 1 && o <= done_off), (o == done_off));
            if (bus_a.vram_wr_en_o && int'(bus_a.vram_wr_address_o) < N &&
                obs_commit_off[bus_a.vram_wr_address_o] < 0)
                obs_commit_off[bus_a.vram_wr_address_o] = o;
            if (bus_a.done_o && obs_done < 0) obs_done = o;
            if (k >= 0) c++;
            @(posedge clk); #1;
        end
        start = 1'b0;
        grant = 1'b1;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s vram_a[%0d]", tag, i), int'(vram_a[i]), int'(init_img[i]));
            chk($sformatf("%s vram_b[%0d]", tag, i), int'(vram_b[i]), int'(init_img[i]));
            chk($sformatf("%s ram_a[%0d]", tag, i),  int'(ram_a[i]),  0);
            chk($sformatf("%s ram_b[%0d]", tag, i),  int'(ram_b[i]),  int'(init_img[i]));
        end
    endtask

    initial begin
        vecs[0] = '{"full",        0,  0, 1'b0, -1,  5,  7, 14};
        vecs[1] = '{"bp_mid",      4,  3, 1'b0, -1,  2,  7, 17};
        vecs[2] = '{"last_stall", 13,  3, 1'b0, -1, 11, 16, 17};
        vecs[3] = '{"gap_t1",      1,  1, 1'b0, -1,  0,  2, 14};
        vecs[4] = '{"stall_first", 2,  2, 1'b0, -1,  0,  4, 16};
        vecs[5] = '{"hold_start",  0,  0, 1'b1, -1, 11, 13, 14};
        vecs[6] = '{"poke_busy",   5,  1, 1'b0,  6,  3,  6, 15};

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle("reset_hold");
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_idle($sformatf("idle%0d", i));
        end
        @(posedge clk); #1;

        for (int v = 0; v < NVEC; v++) begin
            preload(1'b0);
            run_pass(vecs[v].name, 1'b0, vecs[v].stall_from, vecs[v].stall_len,
                     vecs[v].hold_start, vecs[v].poke_at);
            chk({vecs[v].name, " probe_commit_cycle"}, obs_commit_off[vecs[v].probe_addr],
                vecs[v].exp_probe_off);
            chk({vecs[v].name, " done_cycle"}, obs_done, vecs[v].exp_done);
            repeat (2) @(posedge clk);
            #1;
        end

        // Abort after five commits: reset mid-cycle while addr 5 is committing.
        preload(1'b0);
        start = 1'b1;
        grant = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        chk("abort pre vram_wr_en", int'(bus_a.vram_wr_en_o), 1);
        chk("abort pre vram_wr_addr", int'(bus_a.vram_wr_address_o), 5);
        rst_n = 1'b0;
        #1;
        chk_idle("abort_async");
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("abort vram_a[%0d]", i), int'(vram_a[i]), (i < 5) ? int'(init_img[i]) : 3);
            chk($sformatf("abort ram_a[%0d]", i),  int'(ram_a[i]),  (i < 5) ? 0 : int'(init_img[i]));
            chk($sformatf("abort vram_b[%0d]", i), int'(vram_b[i]), (i < 5) ? int'(init_img[i]) : 3);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        preload(1'b0);
        run_pass("restart", 1'b0, 0, 0, 1'b0, 3);
        chk("restart first_commit_cycle", obs_commit_off[0], 2);
        chk("restart done_cycle", obs_done, 14);
        @(posedge clk); #1;

        for (int r = 0; r < 8; r++) begin
            preload(1'b1);
            run_pass($sformatf("rand%0d", r), 1'b1, 0, 0, 1'b0, -1);
            @(posedge clk); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cells_commit.md
Name: cells_commit

Overview:
Copy-back engine that runs after the next-state pass finishes. It reads every cell of the next-state RAM in raster order and writes each value into VRAM at the same address. When CLEAR_RAM=1 it also zeroes each RAM cell after the read, so the next update pass starts from an empty buffer. It sits between the update engine's done pulse and the next update start, and yields VRAM write slots to the display path via vram_grant_i.

Parameters:
ACTIVE_COLUMNS, 640, cells per row
ACTIVE_ROWS, 480, rows; N = ACTIVE_COLUMNS*ACTIVE_ROWS cells
ADDR_WIDTH, $clog2(ACTIVE_COLUMNS*ACTIVE_ROWS), cell address width
DATA_WIDTH, 2, cell state width (0 = empty)
CLEAR_RAM, 1, 1 = write 0 to each RAM cell once it has been committed

Ports:
clk_i  in  1  single clock, all logic on rising edge
reset_i  in  1  asynchronous, active-low reset
start_i  in  1  begin a commit pass; sampled only in IDLE
vram_grant_i  in  1  1 = VRAM write port available this cycle
ram_rd_data_i  in  DATA_WIDTH  next-state RAM data, synchronous read, 1-cycle latency
ram_rd_address_o  out  ADDR_WIDTH  next-state RAM read address
ram_wr_address_o  out  ADDR_WIDTH  RAM clear address
ram_wr_data_o  out  DATA_WIDTH  always 0
ram_wr_en_o  out  1  RAM clear strobe
vram_wr_address_o  out  ADDR_WIDTH  VRAM write address
vram_wr_data_o  out  DATA_WIDTH  committed cell value
vram_wr_en_o  out  1  VRAM write strobe
busy_o  out  1  1 while state != IDLE
done_o  out  1  one-cycle pulse when the pass completes

Behaviour:
- Reset (reset_i=0, async): state IDLE; rd_ptr=0, wr_ptr=0, valid=0; every output 0.
- States: IDLE, COPY, DRAIN, DONE. All outputs are 0 in any cycle where this rule does not drive them.
- IDLE: if start_i=1 → rd_ptr=0, valid=0, go to COPY. start_i is ignored in every other state.
- Pipeline regs:
  - wr_ptr = address whose data is on ram_rd_data_i this cycle.
  - valid = wr_ptr holds a read issued last cycle.
- Commit event: valid=1 AND vram_grant_i=1. In that cycle:
  - vram_wr_en_o=1, vram_wr_address_o=wr_ptr, vram_wr_data_o=ram_rd_data_i.
  - If CLEAR_RAM=1: ram_wr_en_o=1, ram_wr_address_o=wr_ptr, ram_wr_data_o=0.
  - The cell is written to VRAM even when its data is 0, so stale VRAM pixels are overwritten.
- COPY, advance (valid=0 OR vram_grant_i=1):
  - ram_rd_address_o=rd_ptr; next cycle wr_ptr<=rd_ptr, valid<=1.
  - If rd_ptr==N-1 → go to DRAIN; else rd_ptr<=rd_ptr+1.
- COPY, stall (valid=1 AND vram_grant_i=0):
  - ram_rd_address_o=wr_ptr, which re-reads the pending cell so its data is still present next cycle.
  - rd_ptr, wr_ptr and valid are held; no writes.
- DRAIN:
  - Stall: same rule as COPY (re-read wr_ptr, no writes).
  - Commit event: perform the commit, valid<=0, go to DONE.
- DONE: done_o=1 for exactly one cycle, then IDLE. busy_o is still 1 in DONE.
- Hazards:
  - A RAM clear always targets wr_ptr. The read issued in the same cycle targets rd_ptr=wr_ptr+1, so they never collide.
  - During a stall no RAM write occurs.
- Count: exactly N VRAM writes per pass, addresses 0..N-1 strictly ascending. Each address is written exactly once.
- Latency with vram_grant_i held 1 and start_i sampled at cycle T:
  - read addr 0 at T+1;
  - commit of addr k at T+2+k;
  - done_o at T+N+2;
  - IDLE at T+N+3.
  - Each cycle with vram_grant_i=0 while valid=1 adds exactly one cycle.
- Arithmetic: rd_ptr compare against N-1 at full ADDR_WIDTH; no wrap past N-1. N need not be a power of two.
- Reset mid-pass: abort immediately, with no further writes. Partially committed memories are left as-is. The next start_i restarts from address 0.
- start_i held high through DONE does not retrigger until IDLE is reached; in IDLE it retriggers on the next sampled high.

Test Plan:
(Bench uses ACTIVE_COLUMNS=4, ACTIVE_ROWS=3, so N=12, with a behavioural 1-cycle-latency RAM model.)
1. Reset values: assert reset_i=0 mid-cycle → all outputs 0 asynchronously; release, idle 5 cycles → busy_o=0, no write strobes.
2. Full copy: RAM preloaded cell k = k%4, grant=1, start pulse at T → VRAM writes addr 0..11 with data k%4 at T+2..T+13; RAM all 0 afterwards; done_o high only at T+14.
3. Backpressure: grant=0 for cycles T+4..T+6 → addr 2 is committed at T+7 with the correct data; done_o at T+17; no duplicate or skipped addresses.
4. Last-cell stall: grant=0 while addr 11 is pending (DRAIN) for 3 cycles → single write of addr 11 when grant returns; done_o the next cycle.
5. CLEAR_RAM=0: same as scenario 2 → VRAM matches; ram_wr_en_o never asserts; RAM contents unchanged.
6. Abort and restart: reset_i=0 after 5 commits → strobes drop immediately; release and start again → pass restarts at addr 0 and completes 12 writes; start_i pulsed during busy_o is ignored.
